hazard_unit: RTL

Central pipeline-control block for the five-stage MIPS datapath. It is the driving end of the `enable`/`flush` controls on the four pipeline latches: fetch/decode, decode/execute, execute/memory and memory/writeback. Each cycle it decides whether every latch advances, holds or takes a bubble, and it gates the PC. It also sequences processor halt and watches for a hung data-memory access.

---
 rtl/hazard_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline latch/PC control, halt sequencing and data-memory timeout watchdog
// Optional feature macro: HAZARD_PERF_EN (adds stall_cycles / flush_events counters)
module hazard_unit #(
    parameter int unsigned MEM_TIMEOUT = 1023
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       dmemREN_M,
    input  logic       dmemWEN_M,
    input  logic       halt_M,
    input  logic       redirect_EX,
    input  logic [4:0] rs_ID,
    input  logic [4:0] rt_ID,
    input  logic       uses_rt_ID,
    input  logic       memtoReg_EX,
    input  logic [4:0] wdest_EX,
    output logic       pc_en,
    output logic       ifid_enable,
    output logic       ifid_flush,
    output logic       idex_enable,
    output logic       idex_flush,
    output logic       exmem_enable,
    output logic       exmem_flush,
    output logic       memwb_enable,
    output logic       memwb_flush,
    output logic       halted,
    output logic       mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

    state_t      state, state_next;
    logic [15:0] wait_cnt;
    logic        mem_stall, lu_hazard;
    logic        pc_raw;
    logic [3:0]  en_raw, fl_raw;  // [3]=ifid [2]=idex [1]=exmem [0]=memwb
    logic        stall_evt, flush_evt;

    assign mem_stall = (dmemREN_M | dmemWEN_M) & ~dhit;
    assign lu_hazard = memtoReg_EX & (wdest_EX != 5'd0) &
                       ((wdest_EX == rs_ID) | (uses_rt_ID & (wdest_EX == rt_ID)));

    always_comb begin
        state_next = state;
        pc_raw     = 1'b0;
        en_raw     = 4'b0000;
        fl_raw     = 4'b0000;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;
        case (state)
            RUN, MEMWAIT: begin
                if (halt_M && !mem_stall) begin
                    en_raw     = 4'b0001;
                    fl_raw     = 4'b0010;
                    state_next = DRAIN;
                end else if (mem_stall) begin
                    stall_evt  = 1'b1;
                    state_next = MEMWAIT;
                end else begin
                    state_next = RUN;
                    if (redirect_EX) begin
                        pc_raw    = 1'b1;
                        fl_raw    = 4'b1100;
                        en_raw    = 4'b0011;
                        flush_evt = 1'b1;
                    end else if (lu_hazard) begin
                        fl_raw    = 4'b0100;
                        en_raw    = 4'b0011;
                        stall_evt = 1'b1;
                    end else if (!ihit) begin
                        fl_raw    = 4'b1000;
                        en_raw    = 4'b0111;
                        stall_evt = 1'b1;
                    end else begin
                        pc_raw = 1'b1;
                        en_raw = 4'b1111;
                    end
                end
            end
            DRAIN: begin
                fl_raw     = 4'b0001;
                state_next = HALTED;
            end
            default: state_next = HALTED;
        endcase
    end

    // Flush wins over enable; reset forces every control low.
    assign pc_en        = nRST & pc_raw;
    assign ifid_enable  = nRST & en_raw[3] & ~fl_raw[3];
    assign idex_enable  = nRST & en_raw[2] & ~fl_raw[2];
    assign exmem_enable = nRST & en_raw[1] & ~fl_raw[1];
    assign memwb_enable = nRST & en_raw[0] & ~fl_raw[0];
    assign ifid_flush   = nRST & fl_raw[3];
    assign idex_flush   = nRST & fl_raw[2];
    assign exmem_flush  = nRST & fl_raw[1];
    assign memwb_flush  = nRST & fl_raw[0];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            wait_cnt    <= 16'd0;
            halted      <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_next;
            if (!mem_stall)
                wait_cnt <= 16'd0;
            else if (wait_cnt != TIMEOUT)
                wait_cnt <= wait_cnt + 16'd1;
            if (wait_cnt == TIMEOUT)
                mem_timeout <= 1'b1;
            if (state == DRAIN)
                halted <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (stall_evt && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush_evt && flush_events != 32'hFFFF_FFFF)
                flush_events <= flush_events + 32'd1;
        end
    end
`else
    logic unused_evt;
    assign unused_evt = stall_evt ^ flush_evt;
`endif

endmodule
